// File: rtl/ccff_loader.sv
// ccff_loader: host word -> configuration chain serialiser
// with gated chain shifting, optional fabric reset and tail readback.
module ccff_loader #(
  parameter int CHAIN_LEN  = 1024,
  parameter int WORD_W     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              clear,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              chain_reset,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CW  = $clog2(CHAIN_LEN + 1);
  localparam int WCW = $clog2(WORD_W + 1);
  localparam int RBW = $clog2(WORD_W);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CW-1:0]  LEN      = CW'(CHAIN_LEN);
  localparam logic [CW-1:0]  LEN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0] WW       = WCW'(WORD_W);
  localparam logic [RBW-1:0] RB_LAST  = RBW'(WORD_W - 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WORD_W-1:0] r_shreg;
  logic [WCW-1:0]    r_wcnt;
  logic [CW-1:0]     r_bitcnt;
  logic [RCW-1:0]    r_rcnt;
  logic              r_en;
  logic              r_crst;
  logic              r_aborted;
  logic [WORD_W-1:0] r_rb_shreg;
  logic [RBW-1:0]    r_rb_cnt;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;

  logic              w_busy;
  logic              w_abort;
  logic              w_start;
  logic              w_hs;
  logic              w_last_bit;
  logic              w_chain_last;
  logic [31:0]       w_rem32;
  logic [WCW-1:0]    w_wcnt_ld;
  logic [WORD_W-1:0] w_rb_word;

  // Decoded control terms shared by FSM and datapath
  always_comb begin
    w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    w_abort      = abort && w_busy;
    w_start      = !w_busy && start && !abort;
    w_hs         = (r_state == S_FETCH) && word_valid && !abort;
    w_last_bit   = (r_wcnt == WCW'(1));
    w_chain_last = (r_state == S_SHIFT) && (r_bitcnt == LEN_LAST);
    w_rem32      = 32'(LEN - r_bitcnt);
    w_wcnt_ld    = WW;
    if (w_rem32 < 32'(WORD_W))
      w_wcnt_ld = WCW'(w_rem32);
    w_rb_word            = r_rb_shreg;
    w_rb_word[r_rb_cnt]  = ccff_tail;
  end

  // State register
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) w_next = clear ? S_CRST : S_FETCH;
      end
      S_CRST: begin
        if (abort)                 w_next = S_IDLE;
        else if (r_rcnt == RST_LAST) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (abort)           w_next = S_IDLE;
        else if (word_valid) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)            w_next = S_IDLE;
        else if (w_last_bit)  w_next = w_chain_last ? S_DONE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shift datapath, counters, reset pulse and readback packing
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_shreg    <= '0;
      r_wcnt     <= '0;
      r_bitcnt   <= '0;
      r_rcnt     <= '0;
      r_en       <= 1'b0;
      r_crst     <= 1'b0;
      r_aborted  <= 1'b0;
      r_rb_shreg <= '0;
      r_rb_cnt   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_abort) begin
        r_en      <= 1'b0;
        r_crst    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        if (w_start) begin
          r_bitcnt   <= '0;
          r_rb_cnt   <= '0;
          r_rb_shreg <= '0;
          r_aborted  <= 1'b0;
          r_rcnt     <= '0;
          r_crst     <= clear;
        end
        if (r_state == S_CRST) begin
          if (r_rcnt == RST_LAST) r_crst <= 1'b0;
          else                    r_rcnt <= r_rcnt + RCW'(1);
        end
        if (w_hs) begin
          r_shreg <= word_data;
          r_wcnt  <= w_wcnt_ld;
          r_en    <= 1'b1;
        end
        if (r_state == S_SHIFT) begin
          r_shreg  <= r_shreg >> 1;
          r_wcnt   <= r_wcnt - WCW'(1);
          r_bitcnt <= r_bitcnt + CW'(1);
          if (w_last_bit) r_en <= 1'b0;
        end
        if (r_en) begin
          if ((r_rb_cnt == RB_LAST) || w_chain_last) begin
            r_rb_data  <= w_rb_word;
            r_rb_valid <= 1'b1;
            r_rb_shreg <= '0;
            r_rb_cnt   <= '0;
          end else begin
            r_rb_shreg <= w_rb_word;
            r_rb_cnt   <= r_rb_cnt + RBW'(1);
          end
        end
      end
    end
  end

  assign word_ready  = (r_state == S_FETCH);
  assign ccff_head   = r_shreg[0];
  assign chain_en    = r_en;
  assign chain_reset = r_crst;
  assign rb_data     = r_rb_data;
  assign rb_valid    = r_rb_valid;
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed bench for ccff_loader
// with behavioural chain models on 16- and 20-flop instances.
module tb_ccff_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start16, start20;
  logic       clear, abort;
  logic [7:0] wdata;
  logic       wvalid;
  logic       sel;
  logic       pre20;

  logic       rdy16, hd16, en16, crst16, rbv16, bsy16, dn16, ab16;
  logic       rdy20, hd20, en20, crst20, rbv20, bsy20, dn20, ab20;
  logic [7:0] rbd16, rbd20;
  logic [15:0] ch16;
  logic [19:0] ch20;

  logic       w_ready, w_head, w_en, w_reset, w_rbv, w_busy, w_done, w_abtd;
  logic [7:0] w_rbd;

  int n_chk = 0;
  int n_fail = 0;
  int en_cnt, rst_cnt, ovl;
  logic head_q[$];
  logic [7:0] rb_q[$];
  logic [31:0] hv;
  logic [15:0] snap;

  always #5 clk = ~clk;

  ccff_loader #(.CHAIN_LEN(16), .WORD_W(8), .RST_CYCLES(2)) u16 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start16), .clear(clear),
    .abort(abort), .word_data(wdata), .word_valid(wvalid),
    .word_ready(rdy16), .ccff_head(hd16), .chain_en(en16),
    .ccff_tail(ch16[15]), .chain_reset(crst16), .rb_data(rbd16),
    .rb_valid(rbv16), .busy(bsy16), .done(dn16), .aborted(ab16));

  ccff_loader #(.CHAIN_LEN(20), .WORD_W(8), .RST_CYCLES(2)) u20 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start20), .clear(clear),
    .abort(abort), .word_data(wdata), .word_valid(wvalid),
    .word_ready(rdy20), .ccff_head(hd20), .chain_en(en20),
    .ccff_tail(ch20[19]), .chain_reset(crst20), .rb_data(rbd20),
    .rb_valid(rbv20), .busy(bsy20), .done(dn20), .aborted(ab20));

  assign w_ready = sel ? rdy20 : rdy16;
  assign w_head  = sel ? hd20  : hd16;
  assign w_en    = sel ? en20  : en16;
  assign w_reset = sel ? crst20 : crst16;
  assign w_rbv   = sel ? rbv20 : rbv16;
  assign w_rbd   = sel ? rbd20 : rbd16;
  assign w_busy  = sel ? bsy20 : bsy16;
  assign w_done  = sel ? dn20  : dn16;
  assign w_abtd  = sel ? ab20  : ab16;

  // Chain models: shift only on edges closing an enabled cycle
  always @(posedge clk) begin
    if (!rst_n) ch16 <= '0;
    else if (en16) ch16 <= {ch16[14:0], hd16};
    if (pre20) ch20 <= '1;
    else if (en20) ch20 <= {ch20[18:0], hd20};
  end

  // Observe the selected instance mid-cycle
  always @(negedge clk) begin
    if (w_en) begin
      en_cnt++;
      head_q.push_back(w_head);
    end
    if (w_reset) rst_cnt++;
    if (w_reset && w_en) ovl++;
    if (w_rbv) rb_q.push_back(w_rbd);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    en_cnt = 0;
    rst_cnt = 0;
    ovl = 0;
    head_q.delete();
    rb_q.delete();
  endtask

  task automatic start_load(input logic clr);
    @(negedge clk);
    if (sel) start20 = 1'b1;
    else     start16 = 1'b1;
    clear = clr;
    @(negedge clk);
    start16 = 1'b0;
    start20 = 1'b0;
    clear = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    wdata = d;
    wvalid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (w_ready) break;
      @(negedge clk);
    end
    chk("ready_wait", w_ready, 1);
    @(negedge clk);
    chk("hs_to_en", w_en, 1);
    wvalid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200; n++) begin
      if (w_done) break;
      @(negedge clk);
    end
    chk("done_wait", w_done, 1);
    chk("busy_at_done", w_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pack_head();
    hv = '0;
    foreach (head_q[i]) hv[i] = head_q[i];
  endtask

  initial begin
    rst_n = 1'b0;
    start16 = 1'b0;
    start20 = 1'b0;
    clear = 1'b0;
    abort = 1'b0;
    wdata = '0;
    wvalid = 1'b0;
    sel = 1'b0;
    pre20 = 1'b0;
    clr_mon();

    #12;
    chk("rst_en", w_en, 0);
    chk("rst_head", w_head, 0);
    chk("rst_ready", w_ready, 0);
    chk("rst_creset", w_reset, 0);
    chk("rst_busy", w_busy, 0);
    chk("rst_done", w_done, 0);
    chk("rst_aborted", w_abtd, 0);
    chk("rst_rbv", w_rbv, 0);
    chk("rst_rbd", w_rbd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact 16-bit load without clear
    clr_mon();
    start_load(1'b0);
    send_word(8'hA5);
    send_word(8'h3C);
    wait_done();
    chk("t1_en_cycles", en_cnt, 16);
    pack_head();
    chk("t1_head_seq", hv, 32'h3CA5);
    chk("t1_no_creset", rst_cnt, 0);
    hv = '0;
    for (int i = 0; i < 16; i++) hv[i] = ch16[15-i];
    chk("t1_chain", hv, 32'h3CA5);

    // Partial final word on the 20-flop chain
    sel = 1'b1;
    @(negedge clk);
    pre20 = 1'b1;
    @(negedge clk);
    pre20 = 1'b0;
    clr_mon();
    start_load(1'b0);
    send_word(8'hFF);
    send_word(8'h00);
    send_word(8'hFF);
    wait_done();
    chk("t2_en_cycles", en_cnt, 20);
    pack_head();
    chk("t2_head_seq", hv, 32'hF00FF);
    chk("t2_rb_count", rb_q.size(), 3);
    if (rb_q.size() == 3) begin
      chk("t2_rb0", rb_q[0], 8'hFF);
      chk("t2_rb1", rb_q[1], 8'hFF);
      chk("t2_rb2", rb_q[2], 8'h0F);
    end
    hv = '0;
    for (int i = 0; i < 20; i++) hv[i] = ch20[19-i];
    chk("t2_chain", hv, 32'hF00FF);

    // Clear phase before loading
    sel = 1'b0;
    clr_mon();
    start_load(1'b1);
    chk("t3_crst_c1", w_reset, 1);
    chk("t3_ready_c1", w_ready, 0);
    @(negedge clk);
    chk("t3_crst_c2", w_reset, 1);
    @(negedge clk);
    chk("t3_crst_off", w_reset, 0);
    chk("t3_ready_on", w_ready, 1);
    send_word(8'h12);
    send_word(8'h34);
    wait_done();
    chk("t3_crst_cycles", rst_cnt, 2);
    chk("t3_crst_en_ovl", ovl, 0);

    // Host stall between words
    clr_mon();
    start_load(1'b0);
    send_word(8'h5A);
    for (int n = 0; n < 30; n++) begin
      if (w_ready) break;
      @(negedge clk);
    end
    chk("t4_fetch", w_ready, 1);
    snap = ch16;
    en_cnt = 0;
    repeat (10) @(negedge clk);
    chk("t4_stall_en", en_cnt, 0);
    chk("t4_stall_chain", ch16, snap);
    send_word(8'hC3);
    wait_done();
    hv = '0;
    for (int i = 0; i < 16; i++) hv[i] = ch16[15-i];
    chk("t4_chain", hv, 32'hC35A);

    // Abort at bit 5 of word 2
    clr_mon();
    start_load(1'b0);
    send_word(8'h11);
    send_word(8'h22);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_aborted", w_abtd, 1);
    chk("t5_busy", w_busy, 0);
    chk("t5_done", w_done, 0);
    chk("t5_ready", w_ready, 0);
    chk("t5_en_bits", en_cnt, 14);
    chk("t5_rb_count", rb_q.size(), 1);
    repeat (10) @(negedge clk);
    chk("t5_en_after", en_cnt, 14);
    chk("t5_sticky", w_abtd, 1);

    // Reload, then reload again and read back the first load
    start_load(1'b0);
    chk("t6_abort_clr", w_abtd, 0);
    send_word(8'h96);
    send_word(8'h69);
    wait_done();
    clr_mon();
    start_load(1'b0);
    send_word(8'h96);
    send_word(8'h69);
    wait_done();
    chk("t6_rb_count", rb_q.size(), 2);
    if (rb_q.size() == 2) begin
      chk("t6_rb0", rb_q[0], 8'h96);
      chk("t6_rb1", rb_q[1], 8'h69);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
